window_shift_buffer: RTL and testbench
======================================

// Module: window_shift_buffer
// PURPOSE
//  Parametrised row-window shift buffer feeding the sub-pixel interpolation filters.
//  Accepts one row of LANES pixels per transfer and holds the newest DEPTH rows.
//  Presents the whole DEPTH x LANES window as one registered output, row-major or transposed.
//  Uses valid/ready handshakes on both sides and keeps fill/drain state.
//  Replaces the fixed 8x15 byte shift registers in front of the filter array.
// PARAMETERS
//  PIX_W  8   bits per pixel
//  LANES  8   pixels per input row
//  DEPTH  15  rows held in the window (>=1)
//  CNT_W  4   width of fill_cnt; must satisfy 2**CNT_W > DEPTH
// PORTS
//  clock     in   1                  rising-edge clock
//  reset_L   in   1                  asynchronous active-low reset
//  clear_L   in   1                  synchronous active-low flush
//  in_valid  in   1                  in_row holds a valid row
//  in_ready  out  1                  buffer can accept a row this cycle
//  in_row    in   LANES*PIX_W        lane j at [j*PIX_W +: PIX_W]
//  transpose in   1                  0 = row-major window, 1 = lane-major window
//  win_valid out  1                  win_out holds a complete, unconsumed window
//  win_ready in   1                  downstream takes the window this cycle
//  win_out   out  DEPTH*LANES*PIX_W  registered window
//  fill_cnt  out  CNT_W              rows held, saturating at DEPTH
// BEHAVIOUR
//  Reset and clocking
//  - All state updates on posedge clock; reset_L low acts asynchronously.
//  - Reset values: storage=0, win_out=0, fill_cnt=0, state=FILL, win_valid=0.
//  Storage and accept
//  - Storage is row[0..DEPTH-1]; row[0] is the oldest row.
//  - accept = in_valid & in_ready.
//  - On accept: row[i]<=row[i+1] for i<DEPTH-1, and row[DEPTH-1]<=in_row.
//  Window layout
//  - transpose=0: pixel(i,j) at win_out[(i*LANES+j)*PIX_W +: PIX_W].
//  - transpose=1: pixel(i,j) at win_out[(j*DEPTH+i)*PIX_W +: PIX_W].
//  - win_out reloads every edge from next-state storage and the current transpose value.
//    A row accepted at edge k is visible in win_out right after edge k (latency 1).
//    A change of transpose takes effect at the next edge.
//  State machine
//  - FILL: in_ready=1, win_valid=0.
//    On accept fill_cnt++; when fill_cnt==DEPTH-1 at the accept, go to FULL.
//  - FULL: win_valid=1, in_ready=win_ready (stall so an untaken window stays stable).
//    - in_valid & win_ready: shift, stay FULL (next sliding window, stride 1 row).
//    - win_ready & !in_valid: go to DRAINED.
//    - win_ready=0: hold everything.
//  - DRAINED: win_valid=0, in_ready=1. On accept: shift, go to FULL.
//  - fill_cnt stays DEPTH in FULL and DRAINED.
//  Flush and simultaneous events
//  - clear_L=0 at an edge, from any state: storage=0, fill_cnt=0, state=FILL.
//    It overrides a coincident accept and window transfer; in_ready=0 in that cycle.
//  - DEPTH=1: the first accept goes FILL->FULL directly.
//  - reset_L low mid-transfer: aborts immediately to reset values; no partial window is kept.
//  - in_row is ignored when accept=0. win_ready is ignored when win_valid=0.
// TESTING
//  (PIX_W=8, LANES=2, DEPTH=3 unless noted; row r = {r+8'h10, r})
//  1. Fill: rows 0,1,2 with win_ready=0.
//     -> win_valid rises after 3rd accept; fill_cnt=3.
//     -> win_out = 48'h12_02_11_01_10_00; in_ready=0 while win_ready=0.
//  2. Slide: hold in_valid=1, win_ready=1 for rows 3..5.
//     -> win_valid stays 1; windows {1,2,3},{2,3,4},{3,4,5}, one per cycle.
//  3. Drain: in FULL, win_ready=1 with in_valid=0.
//     -> win_valid=0 next cycle; then row 6 accepted -> win_valid=1, window {4,5,6}.
//  4. Transpose: same window, toggle transpose=1.
//     -> next edge win_out = 48'h12_11_10_02_01_00; contents unchanged.
//  5. Flush/reset: clear_L=0 coincident with an accept.
//     -> fill_cnt=0, win_out=0, row dropped.
//     Then reset_L=0 mid-stream -> all outputs 0 without waiting for a clock edge.
//  6. Defaults (8/8/15): 15 random rows.
//     -> win_out (transpose=1) matches the legacy 960-bit lane-major packing bit for bit.

Source files
------------

// File: rtl/window_shift_buffer.sv
// Row-window shift buffer: keeps the newest DEPTH rows of LANES pixels and presents
// them as one registered DEPTH x LANES window, row-major or lane-major.
module window_shift_buffer #(
    parameter int PIX_W = 8,
    parameter int LANES = 8,
    parameter int DEPTH = 15,
    parameter int CNT_W = 4
) (
    input  logic                         clock,
    input  logic                         reset_L,
    input  logic                         clear_L,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*PIX_W-1:0]       in_row,
    input  logic                         transpose,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [DEPTH*LANES*PIX_W-1:0] win_out,
    output logic [CNT_W-1:0]             fill_cnt
);

    // state   | meaning
    // FILL    | fewer than DEPTH rows held since reset/flush; accepts freely
    // FULL    | window complete and offered downstream; input stalls on win_ready
    // DRAINED | last window taken, no new row yet; next accept re-offers a window

    localparam int ROW_W = LANES * PIX_W;
    localparam int WIN_W = DEPTH * ROW_W;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DRAINED = 2'd2
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] row_q    [DEPTH];
    logic [ROW_W-1:0] row_next [DEPTH];
    logic [WIN_W-1:0] win_next;
    logic             accept;

    always_comb begin
        in_ready = 1'b0;
        if (clear_L) begin
            case (state)
                FILL:    in_ready = 1'b1;
                FULL:    in_ready = win_ready;
                DRAINED: in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    // Next-state storage; the window register is loaded from this, giving latency 1.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            row_next[i] = row_q[i];
        end
        if (!clear_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                row_next[i] = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                row_next[i] = row_q[i + 1];
            end
            row_next[DEPTH - 1] = in_row;
        end
    end

    always_comb begin
        win_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (transpose) begin
                    win_next[(j * DEPTH + i) * PIX_W +: PIX_W] = row_next[i][j * PIX_W +: PIX_W];
                end else begin
                    win_next[(i * LANES + j) * PIX_W +: PIX_W] = row_next[i][j * PIX_W +: PIX_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= FILL;
            win_valid <= 1'b0;
            fill_cnt  <= '0;
            win_out   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                row_q[i] <= row_next[i];
            end
            win_out <= win_next;
            if (!clear_L) begin
                state     <= FILL;
                win_valid <= 1'b0;
                fill_cnt  <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (accept) begin
                            fill_cnt <= fill_cnt + CNT_W'(1);
                            if (fill_cnt == CNT_W'(DEPTH - 1)) begin
                                state     <= FULL;
                                win_valid <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        // With in_valid high the shift happens via accept and we stay FULL.
                        if (win_ready && !in_valid) begin
                            state     <= DRAINED;
                            win_valid <= 1'b0;
                        end
                    end
                    DRAINED: begin
                        if (accept) begin
                            state     <= FULL;
                            win_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= FILL;
                        win_valid <= 1'b0;
                        fill_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_shift_buffer.sv
// Directed bench for window_shift_buffer: a small 8/2/3 instance plus a default 8/8/15 instance.
module tb_window_shift_buffer;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic        clear_L = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_row = '0;
    logic        transpose = 1'b0;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [47:0] win_out;
    logic [1:0]  fill_cnt;

    logic         d_in_valid = 1'b0;
    logic         d_in_ready;
    logic [63:0]  d_in_row = '0;
    logic         d_win_valid;
    logic [959:0] d_win_out;
    logic [3:0]   d_fill_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    window_shift_buffer #(.PIX_W(8), .LANES(2), .DEPTH(3), .CNT_W(2)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .clear_L   (clear_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .transpose (transpose),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_out   (win_out),
        .fill_cnt  (fill_cnt)
    );

    window_shift_buffer u_def (
        .clock     (clock),
        .reset_L   (reset_L),
        .clear_L   (1'b1),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_row    (d_in_row),
        .transpose (1'b1),
        .win_valid (d_win_valid),
        .win_ready (1'b0),
        .win_out   (d_win_out),
        .fill_cnt  (d_fill_cnt)
    );

    function automatic logic [15:0] mkrow(input int r);
        return {8'(r + 16), 8'(r)};
    endfunction

    function automatic logic [47:0] win3(input int a, input int b, input int c);
        return {mkrow(c), mkrow(b), mkrow(a)};
    endfunction

    function automatic logic [47:0] win3t(input int a, input int b, input int c);
        return {8'(c + 16), 8'(b + 16), 8'(a + 16), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [63:0]  rows15 [15];
    logic [959:0] exp_def;

    initial begin
        #12;
        chk("reset_win_valid", 64'(win_valid), 64'(0));
        chk("reset_fill_cnt", 64'(fill_cnt), 64'(0));
        chk("reset_win_out", 64'(win_out), 64'(0));
        reset_L = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'(1));

        // Fill with downstream not ready
        in_valid = 1'b1;
        in_row = mkrow(0);
        tick();
        chk("fill1_cnt", 64'(fill_cnt), 64'(1));
        chk("fill1_valid", 64'(win_valid), 64'(0));
        in_row = mkrow(1);
        tick();
        chk("fill2_cnt", 64'(fill_cnt), 64'(2));
        in_row = mkrow(2);
        tick();
        chk("fill3_cnt", 64'(fill_cnt), 64'(3));
        chk("fill3_valid", 64'(win_valid), 64'(1));
        chk("fill3_win", 64'(win_out), 64'(48'h12_02_11_01_10_00));
        chk("fill3_in_ready", 64'(in_ready), 64'(0));
        in_row = mkrow(3);
        tick();
        chk("stall_win", 64'(win_out), 64'(win3(0, 1, 2)));
        chk("stall_valid", 64'(win_valid), 64'(1));

        // Sliding windows
        win_ready = 1'b1;
        tick();
        chk("slide3_win", 64'(win_out), 64'(win3(1, 2, 3)));
        chk("slide3_valid", 64'(win_valid), 64'(1));
        in_row = mkrow(4);
        tick();
        chk("slide4_win", 64'(win_out), 64'(win3(2, 3, 4)));
        in_row = mkrow(5);
        tick();
        chk("slide5_win", 64'(win_out), 64'(win3(3, 4, 5)));
        chk("slide5_valid", 64'(win_valid), 64'(1));

        // Drain then refill by one row
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(win_valid), 64'(0));
        chk("drain_cnt", 64'(fill_cnt), 64'(3));
        chk("drain_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_row = mkrow(6);
        win_ready = 1'b0;
        tick();
        chk("refill_valid", 64'(win_valid), 64'(1));
        chk("refill_win", 64'(win_out), 64'(win3(4, 5, 6)));

        // Transpose applies at the next edge
        in_valid = 1'b0;
        transpose = 1'b1;
        #1;
        chk("transpose_pre_edge", 64'(win_out), 64'(win3(4, 5, 6)));
        tick();
        chk("transpose_win", 64'(win_out), 64'(win3t(4, 5, 6)));
        chk("transpose_valid", 64'(win_valid), 64'(1));
        chk("transpose_ref_pattern", 64'(win3t(0, 1, 2)), 64'(48'h12_11_10_02_01_00));
        transpose = 1'b0;
        tick();
        chk("untranspose_win", 64'(win_out), 64'(win3(4, 5, 6)));

        // Flush overrides a coincident accept and window transfer
        clear_L = 1'b0;
        in_valid = 1'b1;
        win_ready = 1'b1;
        in_row = mkrow(7);
        #1;
        chk("clear_in_ready", 64'(in_ready), 64'(0));
        tick();
        chk("clear_cnt", 64'(fill_cnt), 64'(0));
        chk("clear_win", 64'(win_out), 64'(0));
        chk("clear_valid", 64'(win_valid), 64'(0));
        clear_L = 1'b1;
        in_row = mkrow(8);
        tick();
        chk("post_clear_cnt", 64'(fill_cnt), 64'(1));
        chk("post_clear_win", 64'(win_out), 64'({mkrow(8), 32'h0}));

        // Asynchronous reset mid-stream
        in_row = mkrow(9);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_rst_win", 64'(win_out), 64'(0));
        chk("async_rst_cnt", 64'(fill_cnt), 64'(0));
        chk("async_rst_valid", 64'(win_valid), 64'(0));
        in_valid = 1'b0;
        win_ready = 1'b0;
        tick();
        reset_L = 1'b1;
        tick();

        // Default geometry, lane-major packing
        for (int i = 0; i < 15; i++) begin
            rows15[i] = {$urandom, $urandom};
        end
        exp_def = '0;
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < 8; j++) begin
                exp_def[(j * 15 + i) * 8 +: 8] = rows15[i][j * 8 +: 8];
            end
        end
        d_in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            d_in_row = rows15[i];
            tick();
        end
        d_in_valid = 1'b0;
        chk("def_valid", 64'(d_win_valid), 64'(1));
        chk("def_cnt", 64'(d_fill_cnt), 64'(15));
        chk("def_in_ready", 64'(d_in_ready), 64'(0));
        checks++;
        assert (d_win_out === exp_def) else begin
            failures++;
            for (int k = 0; k < 120; k++) begin
                if (d_win_out[k * 8 +: 8] !== exp_def[k * 8 +: 8]) begin
                    $error("FAIL def_win pixel=%0d observed=%0h expected=%0h", k, d_win_out[k * 8 +: 8], exp_def[k * 8 +: 8]);
                    break;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
